// File: rtl/multi_oscillator_pkg.sv
// Shared definitions for the oscillator family.
//   wave_e : 2-bit per-voice waveform mode (saw, square, triangle, silence)
package osc_pkg;

  typedef enum logic [1:0] {
    WAVE_SAW      = 2'd0,
    WAVE_SQUARE   = 2'd1,
    WAVE_TRIANGLE = 2'd2,
    WAVE_SILENCE  = 2'd3
  } wave_e;

endpackage

// File: rtl/multi_oscillator_shaper.sv
// osc_shaper: purely combinational waveform shaper for one phase value.
//   acc_i    : accumulator phase (PHASE_WIDTH bits)
//   duty_i   : square high fraction, duty_i / 2^DUTY_WIDTH
//   mode_i   : waveform select
//   sample_o : two's-complement signed sample (SAMPLE_SIZE bits)
module osc_shaper
  import osc_pkg::*;
#(
  parameter int unsigned SAMPLE_SIZE = 16,
  parameter int unsigned PHASE_WIDTH = 32,
  parameter int unsigned DUTY_WIDTH  = 8
) (
  input  logic [PHASE_WIDTH-1:0] acc_i,
  input  logic [DUTY_WIDTH-1:0]  duty_i,
  input  wave_e                  mode_i,
  output logic [SAMPLE_SIZE-1:0] sample_o
);

  logic [SAMPLE_SIZE-1:0] p;
  logic [SAMPLE_SIZE-1:0] q;
  logic [SAMPLE_SIZE-1:0] fold;
  logic [PHASE_WIDTH-1:0] thresh;
  logic                   m;

  always_comb begin
    p      = acc_i[PHASE_WIDTH-1 -: SAMPLE_SIZE];
    q      = acc_i[PHASE_WIDTH-2 -: SAMPLE_SIZE];
    m      = acc_i[PHASE_WIDTH-1];
    // second half of the cycle mirrors the first, giving the falling edge
    fold   = m ? ~q : q;
    thresh = {duty_i, {(PHASE_WIDTH-DUTY_WIDTH){1'b0}}};

    sample_o = '0;
    unique case (mode_i)
      WAVE_SAW:      sample_o = {~p[SAMPLE_SIZE-1], p[SAMPLE_SIZE-2:0]};
      WAVE_SQUARE:   sample_o = (acc_i < thresh)
                                ? {1'b0, {(SAMPLE_SIZE-1){1'b1}}}
                                : {1'b1, {(SAMPLE_SIZE-1){1'b0}}};
      WAVE_TRIANGLE: sample_o = {~fold[SAMPLE_SIZE-1], fold[SAMPLE_SIZE-2:0]};
      WAVE_SILENCE:  sample_o = '0;
      default:       sample_o = '0;
    endcase
  end

endmodule

// File: rtl/multi_oscillator.sv
// multi_oscillator: time-multiplexed bank of NUM_VOICES phase-accumulator
// oscillators sharing one AXI-Stream-style sample output. Voices are emitted
// round-robin, one per accepted beat.
//   clk, reset_n  : clock, synchronous active-low reset
//   divisor       : per-voice phase increment, voice v in slice v
//   duty          : per-voice square duty
//   waveform      : per-voice mode (0 saw, 1 square, 2 triangle, 3 silence)
//   phase_reset   : per-voice request to zero that voice's accumulator
//   tvalid/tdata/tuser/tlast/tready : sample stream, tuser = voice index
module multi_oscillator
  import osc_pkg::*;
#(
  parameter int unsigned SAMPLE_SIZE = 16,
  parameter int unsigned NUM_VOICES  = 4,
  parameter int unsigned PHASE_WIDTH = 32,
  parameter int unsigned DUTY_WIDTH  = 8,
  localparam int unsigned VIDX_W     = $clog2(NUM_VOICES)
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_VOICES*PHASE_WIDTH-1:0] divisor,
  input  logic [NUM_VOICES*DUTY_WIDTH-1:0]  duty,
  input  logic [NUM_VOICES*2-1:0]           waveform,
  input  logic [NUM_VOICES-1:0]             phase_reset,
  output logic                              tvalid,
  output logic [SAMPLE_SIZE-1:0]            tdata,
  output logic [VIDX_W-1:0]                 tuser,
  output logic                              tlast,
  input  logic                              tready
);

  localparam logic [VIDX_W-1:0] LAST_IDX = VIDX_W'(NUM_VOICES - 1);

  logic [PHASE_WIDTH-1:0] div_a  [NUM_VOICES];
  logic [DUTY_WIDTH-1:0]  duty_a [NUM_VOICES];
  wave_e                  mode_a [NUM_VOICES];

  logic [PHASE_WIDTH-1:0] acc_q [NUM_VOICES];
  logic [PHASE_WIDTH-1:0] acc_d [NUM_VOICES];
  logic [VIDX_W-1:0]      idx_q, idx_d;
  logic                   tvalid_q, tvalid_d;
  logic [SAMPLE_SIZE-1:0] tdata_q, tdata_d;
  logic [VIDX_W-1:0]      tuser_q, tuser_d;
  logic                   tlast_q, tlast_d;

  logic                   load;
  logic [SAMPLE_SIZE-1:0] shaped;

  always_comb begin
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      div_a[v]  = divisor[v*PHASE_WIDTH +: PHASE_WIDTH];
      duty_a[v] = duty[v*DUTY_WIDTH +: DUTY_WIDTH];
      mode_a[v] = wave_e'(waveform[v*2 +: 2]);
    end
  end

  osc_shaper #(
    .SAMPLE_SIZE (SAMPLE_SIZE),
    .PHASE_WIDTH (PHASE_WIDTH),
    .DUTY_WIDTH  (DUTY_WIDTH)
  ) u_shaper (
    .acc_i    (acc_q[idx_q]),
    .duty_i   (duty_a[idx_q]),
    .mode_i   (mode_a[idx_q]),
    .sample_o (shaped)
  );

  // The output register is either empty or being drained this cycle.
  assign load = !tvalid_q || tready;

  always_comb begin
    idx_d    = idx_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tuser_d  = tuser_q;
    tlast_d  = tlast_q;
    if (load) begin
      tvalid_d = 1'b1;
      tdata_d  = shaped;
      tuser_d  = idx_q;
      tlast_d  = (idx_q == LAST_IDX);
      idx_d    = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end
  end

  // phase_reset wins over the increment; the emitted sample already
  // captured the pre-reset phase through the shaper.
  always_comb begin
    for (int unsigned v = 0; v < NUM_VOICES; v++) begin
      acc_d[v] = acc_q[v];
      if (load && (idx_q == VIDX_W'(v))) begin
        acc_d[v] = acc_q[v] + div_a[v];
      end
      if (phase_reset[v]) begin
        acc_d[v] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        acc_q[v] <= '0;
      end
      idx_q    <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tuser_q  <= '0;
      tlast_q  <= 1'b0;
    end else begin
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        acc_q[v] <= acc_d[v];
      end
      idx_q    <= idx_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tuser_q  <= tuser_d;
      tlast_q  <= tlast_d;
    end
  end

  assign tvalid = tvalid_q;
  assign tdata  = tdata_q;
  assign tuser  = tuser_q;
  assign tlast  = tlast_q;

endmodule

// File: tb/tb_multi_oscillator.sv
// Scoreboard bench for multi_oscillator with default parameters.
module tb_multi_oscillator;

  localparam int NV = 4;
  localparam int PW = 32;
  localparam int DW = 8;
  localparam int SS = 16;

  typedef struct packed {
    logic [SS-1:0] d;
    logic [1:0]    u;
    logic          l;
  } beat_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic tready = 1'b1;

  logic [PW-1:0] div_t  [NV];
  logic [DW-1:0] duty_t [NV];
  logic [1:0]    wave_t [NV];
  logic [NV-1:0] pr_t = '0;

  logic [NV*PW-1:0] divisor;
  logic [NV*DW-1:0] duty;
  logic [NV*2-1:0]  waveform;

  logic          tvalid;
  logic [SS-1:0] tdata;
  logic [1:0]    tuser;
  logic          tlast;

  always #5 clk = ~clk;

  always_comb begin
    divisor  = '0;
    duty     = '0;
    waveform = '0;
    for (int v = 0; v < NV; v++) begin
      divisor[v*PW +: PW]  = div_t[v];
      duty[v*DW +: DW]     = duty_t[v];
      waveform[v*2 +: 2]   = wave_t[v];
    end
  end

  multi_oscillator #(
    .SAMPLE_SIZE (SS),
    .NUM_VOICES  (NV),
    .PHASE_WIDTH (PW),
    .DUTY_WIDTH  (DW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .divisor     (divisor),
    .duty        (duty),
    .waveform    (waveform),
    .phase_reset (pr_t),
    .tvalid      (tvalid),
    .tdata       (tdata),
    .tuser       (tuser),
    .tlast       (tlast),
    .tready      (tready)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference shaping written from the waveform definitions.
  function automatic logic [SS-1:0] ref_shape(input logic [PW-1:0] a,
                                              input logic [DW-1:0] d,
                                              input logic [1:0] w);
    logic [SS-1:0] q;
    q = a[PW-2 -: SS];
    case (w)
      2'd0:    return a[PW-1 -: SS] ^ 16'h8000;
      2'd1:    return (a[PW-1 -: DW] < d) ? 16'h7FFF : 16'h8000;
      2'd2:    begin
                 if (a[PW-1]) q = ~q;
                 return q ^ 16'h8000;
               end
      default: return 16'h0000;
    endcase
  endfunction

  logic [PW-1:0] m_acc [NV];
  int            m_idx   = 0;
  logic          m_valid = 1'b0;
  beat_t         sb[$];
  logic [18:0]   held;
  logic          held_v  = 1'b0;

  // Compare the beat on the outputs, advance the model across the coming
  // edge with the current inputs, then move to the next falling edge.
  task automatic cycle();
    beat_t b;
    if (reset_n) begin
      chk("tvalid", 32'(tvalid), 32'(m_valid));
      if (held_v) chk("hold", 32'({tdata, tuser, tlast}), 32'(held));
      held_v = tvalid && !tready;
      held   = {tdata, tuser, tlast};
      if (tvalid && tready) begin
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          b = sb.pop_front();
          chk("tdata", 32'(tdata), 32'(b.d));
          chk("tuser", 32'(tuser), 32'(b.u));
          chk("tlast", 32'(tlast), 32'(b.l));
        end
      end
      if (!m_valid || tready) begin
        b.d = ref_shape(m_acc[m_idx], duty_t[m_idx], wave_t[m_idx]);
        b.u = 2'(m_idx);
        b.l = (m_idx == NV - 1);
        sb.push_back(b);
        m_acc[m_idx] = m_acc[m_idx] + div_t[m_idx];
        m_idx   = (m_idx + 1) % NV;
        m_valid = 1'b1;
      end
      for (int v = 0; v < NV; v++) if (pr_t[v]) m_acc[v] = '0;
    end else begin
      for (int v = 0; v < NV; v++) m_acc[v] = '0;
      m_idx   = 0;
      m_valid = 1'b0;
      held_v  = 1'b0;
      sb.delete();
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int v = 0; v < NV; v++) begin
      div_t[v]  = 32'(v + 1) << 28;
      duty_t[v] = 8'd128;
      wave_t[v] = 2'd0;
      m_acc[v]  = '0;
    end
    @(negedge clk);
    cycle();
    cycle();
    chk("rst_tvalid", 32'(tvalid), 32'd0);
    chk("rst_tdata", 32'(tdata), 32'd0);
    reset_n = 1'b1;

    // saw on all voices
    cycle();
    chk("first_tdata", 32'(tdata), 32'h8000);
    chk("first_tuser", 32'(tuser), 32'd0);
    repeat (160) cycle();

    // square on voice 2, then duty 0
    wave_t[2] = 2'd1;
    duty_t[2] = 8'd64;
    div_t[2]  = 32'h0400_0000;
    repeat (300) cycle();
    duty_t[2] = 8'd0;
    repeat (40) cycle();

    // triangle on voice 0
    wave_t[0] = 2'd2;
    div_t[0]  = 32'h0800_0000;
    repeat (140) cycle();

    // random backpressure with long stalls and config churn during stalls
    for (int i = 0; i < 1500; i++) begin
      if ((i % 200) >= 180) begin
        tready = 1'b0;
        wave_t[$urandom_range(0, NV-1)] = 2'($urandom_range(0, 3));
        duty_t[$urandom_range(0, NV-1)] = 8'($urandom_range(0, 255));
      end else begin
        tready = ($urandom_range(0, 3) != 0);
      end
      cycle();
    end

    // phase_reset on voice 1 while it is being loaded
    tready = 1'b1;
    for (int v = 0; v < NV; v++) wave_t[v] = 2'd0;
    for (int i = 0; i < 8 && m_idx != 1; i++) cycle();
    pr_t = 4'b0010;
    cycle();
    pr_t = '0;
    repeat (12) cycle();

    // phase_reset on voice 1 during a stall
    tready = 1'b0;
    repeat (3) cycle();
    pr_t = 4'b0010;
    cycle();
    pr_t = '0;
    repeat (2) cycle();
    tready = 1'b1;
    repeat (12) cycle();

    // reset mid-frame
    for (int i = 0; i < 8 && m_idx != 2; i++) cycle();
    reset_n = 1'b0;
    cycle();
    chk("midrst_tvalid", 32'(tvalid), 32'd0);
    chk("midrst_tdata", 32'(tdata), 32'd0);
    reset_n = 1'b1;
    cycle();
    chk("restart_tuser", 32'(tuser), 32'd0);
    repeat (20) cycle();

    // maximal increment wraps every beat
    for (int v = 0; v < NV; v++) div_t[v] = 32'hFFFF_FFFF;
    for (int i = 0; i < 200; i++) begin
      tready = ($urandom_range(0, 2) != 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_oscillator.md
# multi_oscillator

Time-multiplexed bank of NUM_VOICES phase-accumulator oscillators sharing one AXI-Stream-style sample output. Each voice has its own frequency divisor, duty and waveform select (saw, square, triangle, silence). Voices are emitted round-robin, one sample per accepted beat, with the voice index on tuser and tlast on the final voice of each frame. The block sits where the single-voice oscillator sat, ahead of the oversampling filter/decimator and mixer.

## Interface
- SAMPLE_SIZE, 16, output sample width; two's-complement signed.
- NUM_VOICES, 4, number of voices; at least 2.
- PHASE_WIDTH, 32, accumulator width; at least SAMPLE_SIZE+1.
- DUTY_WIDTH, 8, per-voice duty resolution.
- VIDX_W, derived as $clog2(NUM_VOICES); not overridable.

Ports:
- clk  in  1  clock; one clock domain.
- reset_n  in  1  synchronous, active-low reset.
- divisor  in  NUM_VOICES*PHASE_WIDTH  per-voice phase increment; voice v occupies slice v. Increment = 2^PHASE_WIDTH·F/f_voice, where f_voice = beat rate / NUM_VOICES.
- duty  in  NUM_VOICES*DUTY_WIDTH  per-voice square high fraction, duty/2^DUTY_WIDTH.
- waveform  in  NUM_VOICES*2  per-voice mode: 0 saw, 1 square, 2 triangle, 3 silence.
- phase_reset  in  NUM_VOICES  per-voice single-cycle request to zero that voice's accumulator.
- tvalid  out  1  sample valid.
- tdata  out  SAMPLE_SIZE  sample.
- tuser  out  VIDX_W  voice index of tdata.
- tlast  out  1  high when tuser = NUM_VOICES-1.
- tready  in  1  downstream ready.

## Operation
- State: acc[0..NUM_VOICES-1] (PHASE_WIDTH bits each), voice pointer idx, and output registers tvalid, tdata, tuser, tlast.
- Load enable: load = !tvalid | tready.
- On load:
  - The output registers take the shaped sample of acc[idx] (pre-increment value) under waveform[idx] and duty[idx], plus tuser=idx and tlast=(idx==NUM_VOICES-1).
  - acc[idx] advances by divisor[idx], modulo 2^PHASE_WIDTH; carry is discarded.
  - idx increments and wraps from NUM_VOICES-1 to 0.
  - tvalid goes to 1.
- No load: all output registers, acc and idx hold. Outputs are therefore stable under backpressure regardless of config changes.
- Shaping, with p = acc[PHASE_WIDTH-1 -: SAMPLE_SIZE] and m = acc MSB:
  - saw: p with its MSB inverted, a ramp from min to max.
  - square: 0x7FF…F (max) while acc < duty·2^(PHASE_WIDTH-DUTY_WIDTH), else 0x80…0 (min). duty=0 gives constant min.
  - triangle: q = acc[PHASE_WIDTH-2 -: SAMPLE_SIZE]; fold to q if m=0, else ~q; then invert the MSB to make it signed.
  - silence: 0. The accumulator still advances.
- phase_reset[v]: acc[v] becomes 0 next cycle. This has priority over the increment when v==idx on a load cycle; the emitted sample still uses the pre-reset value. Multiple bits may be set at once.
- Config inputs are sampled only on load cycles, for the voice being loaded.

## Timing
- Reset (reset_n low at a clk edge) clears acc[*], idx, tvalid, tdata, tuser and tlast to 0. Reset overrides a simultaneous load and phase_reset.
- First edge after reset release: load (tvalid is 0). tvalid=1 on the following cycle with voice 0 and sample of acc=0 (saw 0x8000, square 0x7FFF if duty>0, triangle 0x8000, silence 0).
- Throughput: one sample per cycle while tready=1. A frame is NUM_VOICES consecutive beats.
- Latency from config change to output: at most NUM_VOICES+1 beats.
- Once set, tvalid stays 1 until reset; it never drops under backpressure.
- Reset asserted mid-frame: the next frame restarts at voice 0. There is no partial-frame completion.

## Structure
- Package osc_pkg: waveform mode localparams (WAVE_SAW, WAVE_SQUARE, WAVE_TRIANGLE, WAVE_SILENCE) and the 2-bit mode typedef.
- Sub-module osc_shaper: purely combinational; inputs acc value, duty and mode; output sample; parametrised by SAMPLE_SIZE, PHASE_WIDTH and DUTY_WIDTH. It is reused by the single-voice design later.
- The top level holds the accumulator array, pointer, load logic and output registers.

## Test plan
- Defaults, all voices saw, divisor v = 2^28·(v+1), tready=1: tuser cycles 0,1,2,3 with tlast on 3. Voice 0 samples go 0x8000, 0x9000, 0xA000… (step 2^12 per frame). Voice 1 steps by 0x2000.
- Square on voice 2, duty=64, divisor=2^26: high (0x7FFF) for 16 frames, then low (0x8000) for 48 frames, periodic. duty=0 gives constant 0x8000.
- Triangle on voice 0, divisor=2^27: 0x8000 rising to 0x7FFF-ish at phase 0.5, then falling, symmetric over 32 frames.
- Random tready including long stalls: tdata, tuser and tlast are held while tvalid&!tready. No sample is skipped or duplicated versus the reference model; toggling duty/waveform during a stall does not change the held beat.
- phase_reset[1] pulsed while idx=1 on a load cycle: the emitted sample uses the old acc, and the next voice-1 sample equals the acc=0 value. Pulsed while stalled: same result.
- reset_n low for one cycle mid-frame (idx=2): tvalid=0, tdata=0 next cycle, and the following stream restarts at voice 0 with acc=0. Divisor 0xFFFFFFFF wraps every beat with no stuck state.
